// File: rtl/tls_pkg.sv
// rtl/tls_pkg.sv - shared types and helpers for the trap load sequencer
package tls_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FILL,
        ST_RELAX,
        ST_FINISH
    } state_t;

    // Widest leaf mask the priority encoder handles (DEPTH <= 6).
    localparam int MAX_LEAVES = 64;

    function automatic int leaves_of(input int depth);
        return 1 << depth;
    endfunction

    function automatic int edges_of(input int depth);
        return (2 << depth) - 2;
    endfunction

    function automatic int lowest_set_bit(input logic [MAX_LEAVES-1:0] mask);
        int idx;
        idx = 0;
        for (int i = MAX_LEAVES - 1; i >= 0; i--) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tree_path_decoder.sv
// rtl/tree_path_decoder.sv - leaf index to root-to-leaf valve vector (heap order)
module tree_path_decoder
    import tls_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic [DEPTH-1:0]           leaf,
    output logic [edges_of(DEPTH)-1:0] valves
);

    // Heap node of the leaf is LEAVES+leaf; each right shift climbs one level.
    always_comb begin
        logic [DEPTH:0] node;
        valves = '0;
        node   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            node = {1'b1, leaf} >> k;
            valves[int'(node) - 2] = 1'b1;
        end
    end

endmodule

// File: rtl/trap_load_sequencer.sv
// rtl/trap_load_sequencer.sv - per-trap valve/pump sequencer for a binary distribution tree
module trap_load_sequencer
    import tls_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int FILL_W = 16,
    parameter int SETTLE = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        pause,
    input  logic [leaves_of(DEPTH)-1:0] leaf_mask,
    input  logic [FILL_W-1:0]           fill_cycles,
    output logic [edges_of(DEPTH)-1:0]  valve_open,
    output logic                        pump_on,
    output logic [DEPTH-1:0]            cur_leaf,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted
);

    localparam int LEAVES = leaves_of(DEPTH);
    localparam int EDGES  = edges_of(DEPTH);
    localparam int CNT_W  = (FILL_W > $clog2(SETTLE + 1)) ? FILL_W : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [LEAVES-1:0]   mask_q, mask_n, remaining;
    logic [FILL_W-1:0]   fill_q, fill_n;
    logic [DEPTH-1:0]    leaf_n;
    logic [EDGES-1:0]    path_valves;
    logic                path_active;
    logic                cnt_zero;

    tree_path_decoder #(.DEPTH(DEPTH)) u_path (
        .leaf   (cur_leaf),
        .valves (path_valves)
    );

    assign busy        = (state != ST_IDLE);
    assign path_active = (state == ST_SETTLE) || (state == ST_FILL) || (state == ST_RELAX);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mask_n    = mask_q;
        fill_n    = fill_q;
        leaf_n    = cur_leaf;
        cnt_zero  = (cnt == '0);
        remaining = mask_q & ~(LEAVES'(1) << cur_leaf);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mask_n = leaf_mask;
                    fill_n = fill_cycles;
                    if (leaf_mask == '0) begin
                        state_n = ST_FINISH;
                    end else begin
                        leaf_n  = DEPTH'(lowest_set_bit(MAX_LEAVES'(leaf_mask)));
                        cnt_n   = SETTLE_LAST;
                        state_n = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!pause) begin
                    if (!cnt_zero) begin
                        cnt_n = cnt - 1'b1;
                    end else if (fill_q == '0) begin
                        cnt_n   = SETTLE_LAST;
                        state_n = ST_RELAX;
                    end else begin
                        cnt_n   = CNT_W'(fill_q - 1'b1);
                        state_n = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (!pause) begin
                    if (!cnt_zero) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
                        cnt_n   = SETTLE_LAST;
                        state_n = ST_RELAX;
                    end
                end
            end
            ST_RELAX: begin
                if (!pause) begin
                    if (!cnt_zero) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
                        mask_n = remaining;
                        if (remaining == '0) begin
                            state_n = ST_FINISH;
                        end else begin
                            leaf_n  = DEPTH'(lowest_set_bit(MAX_LEAVES'(remaining)));
                            cnt_n   = SETTLE_LAST;
                            state_n = ST_SETTLE;
                        end
                    end
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
        if (abort && busy) begin
            state_n = ST_IDLE;
        end
    end

    // Outputs follow the state one cycle later, except abort, which clears them at its own edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mask_q     <= '0;
            fill_q     <= '0;
            cur_leaf   <= '0;
            valve_open <= '0;
            pump_on    <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            mask_q   <= mask_n;
            fill_q   <= fill_n;
            cur_leaf <= leaf_n;
            if (abort && busy) begin
                valve_open <= '0;
                pump_on    <= 1'b0;
                done       <= 1'b0;
                aborted    <= 1'b1;
            end else begin
                valve_open <= path_active ? path_valves : '0;
                pump_on    <= (state == ST_FILL) && !pause;
                done       <= (state == ST_FINISH);
                aborted    <= 1'b0;
            end
        end
    end

endmodule
